// File: rtl/cla_chunk_sequencer.sv
// cla_chunk_sequencer
// -------------------
// Multi-cycle operand sequencer for an external combinational 8-bit
// carry-lookahead slice. A WIDTH-bit add request is accepted over a
// valid/ready port. The block then feeds the slice one CHUNK-bit slice per
// cycle, least significant chunk first. Each cycle the slice carry-out is fed
// back in as the next carry-in. The assembled sum and the final carry are
// presented on a valid/ready result port.
//
// Optional feature: define CLA_SEQ_SUB_EN to add the op_sub input.
// When op_sub=1 the block computes op_a - op_b (two's complement), and
// out_cout=1 means no borrow.
//
// Parameters:
//   WIDTH  operand/result width, a multiple of CHUNK and >= CHUNK
//   CHUNK  slice width (8, matching the lookahead slice)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake
//   op_a, op_b, op_cin   request operands and carry-in
//   op_sub               subtract select (CLA_SEQ_SUB_EN only)
//   add_a/add_b/add_cin  chunk operands and carry driven to the slice
//   add_s/add_cout       slice result, valid in the same cycle
//   out_valid/out_ready  result handshake
//   out_sum, out_cout    assembled sum and final carry-out
//   busy                 high while chunks are being processed
//
// FSM states:
//   state  | meaning
//   S_IDLE | waiting for a request, in_ready=1
//   S_RUN  | one chunk per cycle through the slice, idx = current chunk
//   S_DONE | result valid, held until out_ready; may accept the next request

module cla_chunk_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic [CHUNK-1:0] add_a,
    output logic [CHUNK-1:0] add_b,
    output logic             add_cin,
    input  logic [CHUNK-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              accept;
    logic [WIDTH-1:0]  b_in;
    logic              cin_in;

    // Subtraction is a + ~b + 1, so the slice path is unchanged.
`ifdef CLA_SEQ_SUB_EN
    assign b_in   = op_sub ? ~op_b : op_b;
    assign cin_in = op_sub ? 1'b1  : op_cin;
`else
    assign b_in   = op_b;
    assign cin_in = op_cin;
`endif

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_a   = a_q[CHUNK*int'(idx_q) +: CHUNK];
            add_b   = b_q[CHUNK*int'(idx_q) +: CHUNK];
            add_cin = carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = op_a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                sum_d[CHUNK*int'(idx_q) +: CHUNK] = add_s;
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    cout_d  = add_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        // Next request is taken on the same edge the result
                        // is consumed, so no IDLE cycle is inserted.
                        a_d     = op_a;
                        b_d     = b_in;
                        carry_d = cin_in;
                        idx_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Testbench for cla_chunk_sequencer: a 32-bit instance and an 8-bit
// (single-chunk) instance, each closed around a behavioural 8-bit slice.

module tb_cla_chunk_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // ---------------- 32-bit instance ----------------
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0, op_b = '0;
    logic        op_cin = 1'b0;
    logic        op_sub = 1'b0;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        busy;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    cla_chunk_sequencer #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
`ifdef CLA_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    // ---------------- 8-bit instance ----------------
    logic        in8_valid = 1'b0;
    logic        in8_ready;
    logic [7:0]  op8_a = '0, op8_b = '0;
    logic        op8_cin = 1'b0;
    logic        op8_sub = 1'b0;
    logic [7:0]  add8_a, add8_b, add8_s;
    logic        add8_cin, add8_cout;
    logic        out8_valid;
    logic        out8_ready = 1'b0;
    logic [7:0]  out8_sum;
    logic        out8_cout;
    logic        busy8;

    assign {add8_cout, add8_s} = {1'b0, add8_a} + {1'b0, add8_b} + {8'd0, add8_cin};

    cla_chunk_sequencer #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready),
        .op_a(op8_a), .op_b(op8_b), .op_cin(op8_cin),
`ifdef CLA_SEQ_SUB_EN
        .op_sub(op8_sub),
`endif
        .add_a(add8_a), .add_b(add8_b), .add_cin(add8_cin),
        .add_s(add8_s), .add_cout(add8_cout),
        .out_valid(out8_valid), .out_ready(out8_ready),
        .out_sum(out8_sum), .out_cout(out8_cout), .busy(busy8)
    );

    // ---------------- helpers (stimulus only) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub);
        op_a     = a;
        op_b     = b;
        op_cin   = cin;
        op_sub   = sub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid, bounded at 20.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_valid_busy: got %b%b expected 00", out_valid, busy);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== 32'h0 || out_cout !== 1'b0)
            $display("FAIL reset_sum: got %h/%b expected 00000000/0", out_sum, out_cout);
        else pass_cnt++;
        total_cnt++;
        if (add_a !== 8'h0 || add_b !== 8'h0 || add_cin !== 1'b0)
            $display("FAIL reset_add_bus: got %h %h %b expected 00 00 0", add_a, add_b, add_cin);
        else pass_cnt++;
    endtask

    task automatic test_carry_chain();
        logic exp_cin [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (add_cin !== exp_cin[i])
                $display("FAIL carry_add_cin[%0d]: got %b expected %b", i, add_cin, exp_cin[i]);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b0 || busy !== 1'b1)
                $display("FAIL carry_run_flags[%0d]: got valid=%b busy=%b expected 0 1", i, out_valid, busy);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL carry_latency: out_valid %b at 4 cycles, expected 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_sum !== 32'h0000_0000 || out_cout !== 1'b1)
            $display("FAIL carry_result: got %h/%b expected 00000000/1", out_sum, out_cout);
        else pass_cnt++;
        release_out();
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL carry_to_idle: got valid=%b ready=%b expected 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_chunk_order();
        logic [7:0] exp_a [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        int cyc;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (add_a !== exp_a[i] || add_b !== 8'h11)
                $display("FAIL order_chunk[%0d]: got %h/%h expected %h/11", i, add_a, add_b, exp_a[i]);
            else pass_cnt++;
            step();
        end
        cyc = 4;
        if (out_valid !== 1'b1) wait_done(cyc);
        total_cnt++;
        if (out_valid !== 1'b1 || out_sum !== 32'h2345_678A || out_cout !== 1'b0)
            $display("FAIL order_result: got v=%b %h/%b expected 1 2345678a/0", out_valid, out_sum, out_cout);
        else pass_cnt++;
        release_out();
    endtask

    task automatic test_hold();
        int cyc;
        start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 4) $display("FAIL hold_latency: got %0d cycles expected 4", cyc);
        else pass_cnt++;
        // A pending request must not be taken while the result is stalled.
        op_a     = 32'h0000_0003;
        op_b     = 32'h0000_0004;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || out_sum !== 32'hFFFF_FFFF || out_cout !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL hold_stable[%0d]: got v=%b %h/%b rdy=%b expected 1 ffffffff/0 0",
                         i, out_valid, out_sum, out_cout, in_ready);
            else pass_cnt++;
            total_cnt++;
            if (add_a !== 8'h0 || add_b !== 8'h0 || add_cin !== 1'b0)
                $display("FAIL hold_add_bus[%0d]: got %h %h %b expected 00 00 0", i, add_a, add_b, add_cin);
            else pass_cnt++;
            step();
        end
        in_valid = 1'b0;
        release_out();
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release: got v=%b busy=%b rdy=%b expected 0 0 1", out_valid, busy, in_ready);
        else pass_cnt++;
    endtask

    // Each result occupies one DONE cycle in which the next request is
    // accepted, followed by four RUN cycles: valid pulses 5 cycles apart.
    task automatic test_back_to_back();
        logic [31:0] ra   [3] = '{32'h0000_0001, 32'h8000_0000, 32'h0001_0000};
        logic [31:0] rb   [3] = '{32'h0000_0002, 32'h8000_0000, 32'h0002_0000};
        logic        rc   [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es   [3] = '{32'h0000_0003, 32'h0000_0000, 32'h0003_0001};
        logic        ec   [3] = '{1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        op_a = ra[0]; op_b = rb[0]; op_cin = rc[0]; op_sub = 1'b0;
        in_valid = 1'b1;
        step();
        for (int k = 0; k < 15; k++) begin
            if (k % 5 == 0) begin
                if (k / 5 + 1 < 3) begin
                    op_a = ra[k/5+1]; op_b = rb[k/5+1]; op_cin = rc[k/5+1];
                end else begin
                    in_valid = 1'b0;
                end
            end
            total_cnt++;
            if (out_valid !== (k % 5 == 4) || busy !== (k % 5 != 4))
                $display("FAIL b2b_flags[%0d]: got v=%b busy=%b expected %b %b",
                         k, out_valid, busy, (k % 5 == 4), (k % 5 != 4));
            else pass_cnt++;
            if (k % 5 == 4) begin
                total_cnt++;
                if (out_sum !== es[k/5] || out_cout !== ec[k/5])
                    $display("FAIL b2b_result[%0d]: got %h/%b expected %h/%b",
                             k / 5, out_sum, out_cout, es[k/5], ec[k/5]);
                else pass_cnt++;
            end
            step();
        end
        out_ready = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL b2b_idle: got busy=%b v=%b rdy=%b expected 0 0 1", busy, out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        start_op(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL abort_state: got busy=%b v=%b sum=%h rdy=%b expected 0 0 00000000 1",
                     busy, out_valid, out_sum, in_ready);
        else pass_cnt++;
        // Reset on the same edge as a request: the request is dropped.
        op_a = 32'h5; op_b = 32'h5; in_valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_over_accept: got busy=%b rdy=%b expected 0 1", busy, in_ready);
        else pass_cnt++;
        start_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 4 || out_sum !== 32'h0000_0002 || out_cout !== 1'b0)
            $display("FAIL abort_next_op: got %0d cycles %h/%b expected 4 00000002/0", cyc, out_sum, out_cout);
        else pass_cnt++;
        release_out();
    endtask

    task automatic test_single_chunk();
        op8_a = 8'hFF; op8_b = 8'h01; op8_cin = 1'b0; in8_valid = 1'b1;
        step();
        in8_valid = 1'b0;
        total_cnt++;
        if (busy8 !== 1'b1 || add8_a !== 8'hFF || add8_cin !== 1'b0)
            $display("FAIL w8_run: got busy=%b a=%h cin=%b expected 1 ff 0", busy8, add8_a, add8_cin);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out8_valid !== 1'b1 || out8_sum !== 8'h00 || out8_cout !== 1'b1)
            $display("FAIL w8_result: got v=%b %h/%b expected 1 00/1", out8_valid, out8_sum, out8_cout);
        else pass_cnt++;
        out8_ready = 1'b1;
        step();
        out8_ready = 1'b0;
        total_cnt++;
        if (out8_valid !== 1'b0 || in8_ready !== 1'b1)
            $display("FAIL w8_idle: got v=%b rdy=%b expected 0 1", out8_valid, in8_ready);
        else pass_cnt++;
    endtask

`ifdef CLA_SEQ_SUB_EN
    task automatic test_subtract();
        int cyc;
        start_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 4 || out_sum !== 32'hFFFF_FFFE || out_cout !== 1'b0)
            $display("FAIL sub_borrow: got %0d cycles %h/%b expected 4 fffffffe/0", cyc, out_sum, out_cout);
        else pass_cnt++;
        release_out();
        start_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
        wait_done(cyc);
        total_cnt++;
        if (cyc != 4 || out_sum !== 32'h0000_0002 || out_cout !== 1'b1)
            $display("FAIL sub_no_borrow: got %0d cycles %h/%b expected 4 00000002/1", cyc, out_sum, out_cout);
        else pass_cnt++;
        release_out();
        op_sub = 1'b0;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_carry_chain();
        test_chunk_order();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
        test_single_chunk();
`ifdef CLA_SEQ_SUB_EN
        test_subtract();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
